// File: rtl/fuzzifier_seq.sv
// Time-multiplexed trapezoidal fuzzifier: one shared evaluator walks NSETS sets per sample.
// Optional breakpoint-ordering check enabled by defining FUZZIFIER_CFG_CHECK_EN.
module fuzzifier_seq #(
    parameter int XW    = 8,
    parameter int NSETS = 3,
    parameter int MUW   = 16
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         cfg_we,
    input  logic [((NSETS > 1) ? $clog2(NSETS) : 1)-1:0] cfg_set,
    input  logic [1:0]                                   cfg_pt,
    input  logic [XW-1:0]                                cfg_data,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [XW-1:0]                                x_in,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [NSETS*MUW-1:0]                         mu_out,
    output logic [NSETS-1:0]                             cfg_err
);

    localparam int SW = (NSETS > 1) ? $clog2(NSETS) : 1;
    localparam int PW = XW + MUW;
    localparam logic [MUW-1:0] MU_ONE   = {1'b0, {(MUW-1){1'b1}}};
    localparam logic [SW-1:0]  LAST_IDX = SW'(NSETS - 1);
    localparam logic [SW:0]    NSETS_W  = (SW+1)'(NSETS);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EVAL = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]              state;
    logic [SW-1:0]           idx;
    logic signed [XW-1:0]    x_p0;
    logic signed [XW-1:0]    bank   [NSETS][4];
    logic signed [XW-1:0]    shadow [NSETS][4];
    logic [MUW-1:0]          mu_reg [NSETS];

    logic signed [XW-1:0]    sa, sb, sc, sd;
    logic signed [XW:0]      num, den;
    logic [MUW-1:0]          mu_rule;
    logic [MUW-1:0]          mu_eval;
    logic                    bad_order;

    function automatic logic signed [XW:0] diff_ext(input logic signed [XW-1:0] p,
                                                    input logic signed [XW-1:0] q);
        return $signed({p[XW-1], p}) - $signed({q[XW-1], q});
    endfunction

    function automatic logic [MUW-1:0] sat_mu(input logic [PW-1:0] q);
        if (q > {{XW{1'b0}}, MU_ONE})
            return MU_ONE;
        return q[MUW-1:0];
    endfunction

    // Both operands are nonnegative in their branch, so only the low XW bits carry magnitude.
    function automatic logic [MUW-1:0] scale(input logic signed [XW:0] n,
                                             input logic signed [XW:0] d);
        logic [PW-1:0] prod;
        logic [PW-1:0] dvsr;
        prod = {{MUW{1'b0}}, n[XW-1:0]} * {{XW{1'b0}}, MU_ONE};
        dvsr = {{MUW{1'b0}}, d[XW-1:0]};
        if (dvsr == '0)
            return MU_ONE;
        return sat_mu(prod / dvsr);
    endfunction

    function automatic logic misordered(input logic signed [XW-1:0] a,
                                        input logic signed [XW-1:0] b,
                                        input logic signed [XW-1:0] c,
                                        input logic signed [XW-1:0] d);
        return !((a <= b) && (b <= c) && (c <= d));
    endfunction

    assign sa = shadow[idx][0];
    assign sb = shadow[idx][1];
    assign sc = shadow[idx][2];
    assign sd = shadow[idx][3];

    // First matching rule wins; the edge branches share one divider through num/den.
    always_comb begin
        num     = '0;
        den     = '0;
        mu_rule = '0;
        if ((sb <= x_p0) && (x_p0 <= sc)) begin
            mu_rule = MU_ONE;
        end else if ((x_p0 <= sa) || (x_p0 >= sd)) begin
            mu_rule = '0;
        end else begin
            if (x_p0 < sb) begin
                num = diff_ext(x_p0, sa);
                den = diff_ext(sb, sa);
            end else begin
                num = diff_ext(sd, x_p0);
                den = diff_ext(sd, sc);
            end
            mu_rule = scale(num, den);
        end
    end

    assign bad_order = misordered(sa, sb, sc, sd);

`ifdef FUZZIFIER_CFG_CHECK_EN
    logic [NSETS-1:0] err_reg;

    assign mu_eval = bad_order ? '0 : mu_rule;
    assign cfg_err = err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= '0;
        end else if (state == ST_IDLE && in_valid) begin
            err_reg <= '0;
        end else if (state == ST_EVAL) begin
            err_reg[idx] <= bad_order;
        end
    end
`else
    logic unused_order;

    assign unused_order = bad_order;
    assign mu_eval      = mu_rule;
    assign cfg_err      = '0;
`endif

    // Active bank takes writes any time; the shadow copy freezes at accept for the whole sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            idx   <= '0;
            x_p0  <= '0;
            for (int i = 0; i < NSETS; i++) begin
                mu_reg[i] <= '0;
                for (int p = 0; p < 4; p++) begin
                    bank[i][p]   <= '0;
                    shadow[i][p] <= '0;
                end
            end
        end else begin
            if (cfg_we && ({1'b0, cfg_set} < NSETS_W))
                bank[cfg_set][cfg_pt] <= cfg_data;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        x_p0   <= x_in;
                        shadow <= bank;
                        idx    <= '0;
                        state  <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    mu_reg[idx] <= mu_eval;
                    idx         <= idx + SW'(1);
                    if (idx == LAST_IDX)
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    always_comb begin
        mu_out = '0;
        for (int i = 0; i < NSETS; i++)
            mu_out[i*MUW +: MUW] = mu_reg[i];
    end

endmodule

// File: tb/tb_fuzzifier_seq.sv
// Self-checking bench for fuzzifier_seq: directed cases plus randomized samples against
// an arithmetic model of the trapezoid rules.
module tb_fuzzifier_seq;

    localparam int XW     = 8;
    localparam int NSETS  = 3;
    localparam int MUW    = 16;
    localparam int SW     = 2;
    localparam int MU_ONE = (1 << (MUW - 1)) - 1;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   cfg_we;
    logic [SW-1:0]          cfg_set;
    logic [1:0]             cfg_pt;
    logic [XW-1:0]          cfg_data;
    logic                   in_valid;
    logic                   in_ready;
    logic [XW-1:0]          x_in;
    logic                   out_valid;
    logic                   out_ready;
    logic [NSETS*MUW-1:0]   mu_out;
    logic [NSETS-1:0]       cfg_err;

    int compared   = 0;
    int mismatched = 0;
    int cfg_m [NSETS][4];

    fuzzifier_seq #(.XW(XW), .NSETS(NSETS), .MUW(MUW)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_set(cfg_set), .cfg_pt(cfg_pt),
        .cfg_data(cfg_data), .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
        .out_valid(out_valid), .out_ready(out_ready), .mu_out(mu_out), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic bit bad_set(int i);
        return !(cfg_m[i][0] <= cfg_m[i][1] && cfg_m[i][1] <= cfg_m[i][2] &&
                 cfg_m[i][2] <= cfg_m[i][3]);
    endfunction

    function automatic int mu_ref(int i, int x);
        int a, b, c, d, r;
        a = cfg_m[i][0]; b = cfg_m[i][1]; c = cfg_m[i][2]; d = cfg_m[i][3];
`ifdef FUZZIFIER_CFG_CHECK_EN
        if (bad_set(i)) return 0;
`endif
        if (b <= x && x <= c)      r = MU_ONE;
        else if (x <= a || x >= d) r = 0;
        else if (a < x && x < b)   r = ((x - a) * MU_ONE) / (b - a);
        else                       r = ((d - x) * MU_ONE) / (d - c);
        return (r > MU_ONE) ? MU_ONE : r;
    endfunction

    function automatic logic [NSETS*MUW-1:0] model_mu(int x);
        logic [NSETS*MUW-1:0] v;
        v = '0;
        for (int i = 0; i < NSETS; i++) v[i*MUW +: MUW] = MUW'(mu_ref(i, x));
        return v;
    endfunction

    function automatic logic [NSETS-1:0] model_err();
        logic [NSETS-1:0] e;
        e = '0;
`ifdef FUZZIFIER_CFG_CHECK_EN
        for (int i = 0; i < NSETS; i++) e[i] = bad_set(i);
`endif
        return e;
    endfunction

    task automatic set_cfg(input int s, input int p, input int d);
        cfg_we = 1'b1; cfg_set = SW'(s); cfg_pt = 2'(p); cfg_data = XW'(d);
        @(posedge clk); #1;
        cfg_we = 1'b0;
        if (s < NSETS) cfg_m[s][p] = d;
    endtask

    task automatic set_trap(input int s, input int a, input int b, input int c, input int d);
        set_cfg(s, 0, a); set_cfg(s, 1, b); set_cfg(s, 2, c); set_cfg(s, 3, d);
    endtask

    // mode 0: no write; 1: write on the accept edge; 2: write during the first EVAL cycle
    task automatic run_sample(input int x, input int mode, input int ws, input int wp,
                              input int wd, output logic [NSETS*MUW-1:0] mu,
                              output logic [NSETS-1:0] err, output int lat);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        in_valid = 1'b1; x_in = XW'(x);
        if (mode == 1) begin cfg_we = 1'b1; cfg_set = SW'(ws); cfg_pt = 2'(wp); cfg_data = XW'(wd); end
        @(posedge clk); #1;
        in_valid = 1'b0; lat = 0;
        if (mode == 1) begin cfg_we = 1'b0; if (ws < NSETS) cfg_m[ws][wp] = wd; end
        if (mode == 2) begin
            cfg_we = 1'b1; cfg_set = SW'(ws); cfg_pt = 2'(wp); cfg_data = XW'(wd);
            @(posedge clk); #1;
            cfg_we = 1'b0; lat = 1;
            if (ws < NSETS) cfg_m[ws][wp] = wd;
        end
        while (out_valid !== 1'b1 && lat < 50) begin @(posedge clk); #1; lat++; end
        mu = mu_out; err = cfg_err;
        if (out_valid !== 1'b1) lat = -1;
    endtask

    task automatic test_reset();
        logic [NSETS*MUW-1:0] mu;
        logic [NSETS-1:0]     err;
        int lat;
        repeat (2) @(posedge clk); #1;
        compared++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || mu_out !== '0 || cfg_err !== '0) begin
            mismatched++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b mu_out=%h cfg_err=%b, required 1 0 0 0",
                     in_ready, out_valid, mu_out, cfg_err);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_sample(0, 0, 0, 0, 0, mu, err, lat);
        for (int i = 0; i < NSETS; i++) begin
            compared++;
            if (mu[i*MUW +: MUW] !== 16'h7FFF) begin
                mismatched++;
                $display("FAIL reset_plateau set%0d: got %h required 7fff", i, mu[i*MUW +: MUW]);
            end
        end
    endtask

    task automatic test_basic();
        logic [NSETS*MUW-1:0] mu;
        logic [NSETS-1:0]     err;
        int lat;
        int exp_v [3] = '{16383, 16383, 0};
        set_trap(0, -128, -128, -64, 0);
        set_trap(1, -64, 0, 0, 64);
        set_trap(2, 0, 64, 127, 127);
        run_sample(-32, 0, 0, 0, 0, mu, err, lat);
        compared++;
        if (lat !== NSETS) begin
            mismatched++;
            $display("FAIL basic_latency: got %0d required %0d", lat, NSETS);
        end
        for (int i = 0; i < 3; i++) begin
            compared++;
            if (mu[i*MUW +: MUW] !== MUW'(exp_v[i])) begin
                mismatched++;
                $display("FAIL basic_x-32 set%0d: got %0d required %0d", i, mu[i*MUW +: MUW], exp_v[i]);
            end
        end
    endtask

    task automatic test_points();
        logic [NSETS*MUW-1:0] mu;
        logic [NSETS-1:0]     err;
        int lat;
        int xs   [2]    = '{-100, 64};
        int exps [2][3] = '{'{32767, 0, 0}, '{0, 0, 32767}};
        for (int k = 0; k < 2; k++) begin
            run_sample(xs[k], 0, 0, 0, 0, mu, err, lat);
            for (int i = 0; i < 3; i++) begin
                compared++;
                if (mu[i*MUW +: MUW] !== MUW'(exps[k][i])) begin
                    mismatched++;
                    $display("FAIL points_x%0d set%0d: got %0d required %0d",
                             xs[k], i, mu[i*MUW +: MUW], exps[k][i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [NSETS*MUW-1:0] held, exp1, exp2;
        int n;
        exp1 = model_mu(-32);
        exp2 = model_mu(64);
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        out_ready = 1'b0; in_valid = 1'b1; x_in = XW'(-32);
        @(posedge clk); #1;
        x_in = XW'(64);
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        compared++;
        if (n !== NSETS) begin
            mismatched++;
            $display("FAIL bp_latency: got %0d required %0d", n, NSETS);
        end
        held = mu_out;
        compared++;
        if (held !== exp1) begin
            mismatched++;
            $display("FAIL bp_result: got %h required %h", held, exp1);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            compared++;
            if (mu_out !== held || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                mismatched++;
                $display("FAIL bp_hold cycle%0d: mu_out=%h in_ready=%b out_valid=%b required %h 0 1",
                         c, mu_out, in_ready, out_valid, held);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        compared++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        compared++;
        if (in_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL bp_held_accept: in_ready=%b required 0", in_ready);
        end
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        compared++;
        if (mu_out !== exp2 || out_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL bp_second: got %h valid=%b required %h", mu_out, out_valid, exp2);
        end
    endtask

    task automatic test_midwrite();
        logic [NSETS*MUW-1:0] mu, exp_v;
        logic [NSETS-1:0]     err;
        int lat;
        int want [4] = '{16383, 10922, 10922, 16383};
        int mode [4] = '{2, 0, 1, 0};
        int wdat [4] = '{32, 0, 0, 0};
        for (int k = 0; k < 4; k++) begin
            exp_v = model_mu(-32);
            run_sample(-32, mode[k], 1, 1, wdat[k], mu, err, lat);
            compared++;
            if (mu !== exp_v || mu[MUW +: MUW] !== MUW'(want[k])) begin
                mismatched++;
                $display("FAIL midwrite step%0d: got %h (zero=%0d) required %h (zero=%0d)",
                         k, mu, mu[MUW +: MUW], exp_v, want[k]);
            end
        end
    endtask

    task automatic test_midreset();
        logic [NSETS*MUW-1:0] mu;
        logic [NSETS-1:0]     err;
        int lat, n, seen;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        in_valid = 1'b1; x_in = XW'(-32);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        compared++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || mu_out !== '0) begin
            mismatched++;
            $display("FAIL midreset_async: out_valid=%b in_ready=%b mu_out=%h required 0 1 0",
                     out_valid, in_ready, mu_out);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < NSETS; i++) for (int p = 0; p < 4; p++) cfg_m[i][p] = 0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        compared++;
        if (seen !== 0) begin
            mismatched++;
            $display("FAIL midreset_no_output: out_valid seen %0d cycles required 0", seen);
        end
        run_sample(0, 0, 0, 0, 0, mu, err, lat);
        compared++;
        if (mu !== {NSETS{16'h7FFF}}) begin
            mismatched++;
            $display("FAIL midreset_zero_bank x0: got %h required all 7fff", mu);
        end
        run_sample(5, 0, 0, 0, 0, mu, err, lat);
        compared++;
        if (mu !== '0) begin
            mismatched++;
            $display("FAIL midreset_zero_bank x5: got %h required 0", mu);
        end
`ifdef FUZZIFIER_CFG_CHECK_EN
        set_trap(2, 64, 0, 127, 127);
        run_sample(32, 0, 0, 0, 0, mu, err, lat);
        compared++;
        if (err !== 3'b100 || mu[2*MUW +: MUW] !== '0) begin
            mismatched++;
            $display("FAIL cfg_check: err=%b mu_pos=%0d required 100 0", err, mu[2*MUW +: MUW]);
        end
        set_trap(2, 0, 64, 127, 127);
        run_sample(32, 0, 0, 0, 0, mu, err, lat);
        compared++;
        if (err !== 3'b000) begin
            mismatched++;
            $display("FAIL cfg_check_clear: err=%b required 000", err);
        end
`endif
    endtask

    task automatic test_random();
        logic [NSETS*MUW-1:0] mu, exp_v;
        logic [NSETS-1:0]     err, exp_e;
        int lat, x, s, md, v [4], t;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                s = $urandom_range(0, 3);
                for (int p = 0; p < 4; p++) v[p] = $urandom_range(0, 255) - 128;
                if ($urandom_range(0, 3) != 0)
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3 - i; j++)
                            if (v[j] > v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
                set_trap(s, v[0], v[1], v[2], v[3]);
            end
            x  = $urandom_range(0, 255) - 128;
            md = $urandom_range(0, 2);
            exp_v = model_mu(x);
            exp_e = model_err();
            run_sample(x, md, $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 255) - 128, mu, err, lat);
            compared++;
            if (mu !== exp_v || err !== exp_e || lat !== NSETS + 0) begin
                mismatched++;
                $display("FAIL random it%0d x=%0d: mu=%h err=%b lat=%0d required %h %b %0d",
                         it, x, mu, err, lat, exp_v, exp_e, NSETS);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_set = '0; cfg_pt = '0; cfg_data = '0;
        in_valid = 1'b0; x_in = '0; out_ready = 1'b1;
        for (int i = 0; i < NSETS; i++) for (int p = 0; p < 4; p++) cfg_m[i][p] = 0;
        test_reset();
        test_basic();
        test_points();
        test_backpressure();
        test_midwrite();
        test_midreset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
